// File: rtl/hilo_control_unit_pkg.sv
// Shared decode constants for the MIPS Decode stage: opcode/funct/REGIMM codes, branch-variant
// and ALU-op encodings, multiply/divide operation codes, sequencer states, the Execute control
// bundle type and the opcode/ALU-control decoder functions.
package hilo_control_unit_pkg;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes, instruction[5:0]
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  // REGIMM sub-opcodes in the rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;

  // Branch variants resolved in Decode
  localparam logic [2:0] BV_NONE      = 3'd0;
  localparam logic [2:0] BV_BEQ       = 3'd1;
  localparam logic [2:0] BV_BNE       = 3'd2;
  localparam logic [2:0] BV_BLTZ      = 3'd3;
  localparam logic [2:0] BV_JUMP      = 3'd4;
  localparam logic [2:0] BV_JUMP_LINK = 3'd5;
  localparam logic [2:0] BV_JUMP_REG  = 3'd6;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  // Multiply/divide operation codes sent with muldiv_start_e
  localparam logic [1:0] MULTDIV_MULT  = 2'd0;
  localparam logic [1:0] MULTDIV_MULTU = 2'd1;
  localparam logic [1:0] MULTDIV_DIV   = 2'd2;
  localparam logic [1:0] MULTDIV_DIVU  = 2'd3;

  typedef enum logic {
    HiloIdle = 1'b0,
    HiloBusy = 1'b1
  } hilo_state_e;

  // Control bundle registered into Execute; all-zero is a bubble
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dest;
    logic       syscall;
    logic       is_mf_hi;
    logic       is_mf_lo;
    logic       is_byte;
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic [1:0] muldiv_op;
    logic       muldiv_start;
  } ctrl_t;

  // Opcodes that carry a 16-bit immediate operand into the ALU
  function automatic logic is_imm_type(input logic [5:0] opcode);
    return opcode inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_LUI,
                          OP_LB, OP_LW, OP_SB, OP_SW};
  endfunction

  function automatic logic [3:0] alu_op_decode(input logic [5:0] opcode,
                                               input logic [5:0] funct);
    logic [3:0] op;
    op = ALU_ADD;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        F_SUB, F_SUBU:  op = ALU_SUB;
        F_AND:          op = ALU_AND;
        F_OR:           op = ALU_OR;
        F_XOR:          op = ALU_XOR;
        F_NOR:          op = ALU_NOR;
        F_SLT:          op = ALU_SLT;
        F_SLTU:         op = ALU_SLTU;
        F_SLL, F_SLLV:  op = ALU_SLL;
        F_SRL, F_SRLV:  op = ALU_SRL;
        F_SRA, F_SRAV:  op = ALU_SRA;
        default:        op = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_SLTI:        op = ALU_SLT;
        OP_SLTIU:       op = ALU_SLTU;
        OP_ORI:         op = ALU_OR;
        OP_LUI:         op = ALU_SLL;  // immediate shifted left by 16
        OP_BEQ, OP_BNE: op = ALU_SUB;
        default:        op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: tracks one in-flight multiply or divide, raises the Decode stall for any
// HI/LO consumer or producer while busy, and pulses done in the cycle HI/LO is written.
// Ports: clk_i, rst_ni (synchronous, active low), valid_i/muldiv_i/mf_i/flush_i/is_div_i from
// Decode; busy_o, done_o, stall_o, issue_o.
module hilo_sequencer
  import hilo_control_unit_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned DIV_LATENCY  = 32,
  parameter int unsigned CNT_W        = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic muldiv_i,
  input  logic mf_i,
  input  logic flush_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o,
  output logic stall_o,
  output logic issue_o
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LATENCY - 1);

  hilo_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;

  assign busy_o  = (state_q == HiloBusy);
  assign done_o  = busy_o && (cnt_q == '0);
  // Busy covers the done cycle, so nothing can issue while HI/LO is being written.
  assign stall_o = valid_i & busy_o & (muldiv_i | mf_i);
  assign issue_o = valid_i & muldiv_i & ~stall_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HiloIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        HiloIdle: begin
          if (issue_o) begin
            state_q <= HiloBusy;
            cnt_q   <= is_div_i ? DivLoad : MultLoad;
          end
        end
        HiloBusy: begin
          if (cnt_q == '0) begin
            state_q <= HiloIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= HiloIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hilo_control_unit.sv
// Decode-stage control unit: full opcode/funct decode, combinational branch class and
// immediate-extension select, Execute control register, and HI/LO hazard stall via the
// sequencer.
// Ports: clk, reset_n (synchronous, active low); Decode inputs opcode/funct/instr_shamt/
// reg_rt_id/valid_d, flush_e from the hazard unit; Decode outputs branch_variant_d,
// imm_is_unsigned_d, hilo_stall_d; registered *_e control bits; hilo_busy, hilo_done.
module hilo_control_unit
  import hilo_control_unit_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned DIV_LATENCY  = 32,
  parameter int unsigned CNT_W        = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] instr_shamt,
  input  logic [4:0] reg_rt_id,
  input  logic       valid_d,
  input  logic       flush_e,
  output logic [2:0] branch_variant_d,
  output logic       imm_is_unsigned_d,
  output logic       hilo_stall_d,
  output logic       reg_write_e,
  output logic       mem_to_reg_e,
  output logic       mem_write_e,
  output logic       alu_src_e,
  output logic       reg_dest_e,
  output logic       syscall_e,
  output logic       is_mf_hi_e,
  output logic       is_mf_lo_e,
  output logic       is_byte_e,
  output logic [3:0] alu_op_e,
  output logic [4:0] shamt_e,
  output logic [1:0] muldiv_op_e,
  output logic       muldiv_start_e,
  output logic       hilo_busy,
  output logic       hilo_done
);

  logic       is_special;
  logic       muldiv_d;
  logic       mf_d;
  logic       issue;
  logic [2:0] bv_raw;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign is_special = (opcode == OP_SPECIAL);
  assign muldiv_d   = is_special && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign mf_d       = is_special && (funct inside {F_MFHI, F_MFLO});

  assign imm_is_unsigned_d = (opcode == OP_ORI) || (opcode == OP_SLTIU);

  hilo_sequencer #(
    .MULT_LATENCY (MULT_LATENCY),
    .DIV_LATENCY  (DIV_LATENCY),
    .CNT_W        (CNT_W)
  ) u_hilo_sequencer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .valid_i  (valid_d),
    .muldiv_i (muldiv_d),
    .mf_i     (mf_d),
    .flush_i  (flush_e),
    .is_div_i (funct[1]),  // DIV/DIVU are the only muldiv functs with bit 1 set
    .busy_o   (hilo_busy),
    .done_o   (hilo_done),
    .stall_o  (hilo_stall_d),
    .issue_o  (issue)
  );

  always_comb begin
    bv_raw = BV_NONE;
    case (opcode)
      OP_REGIMM:  if (reg_rt_id == RT_BLTZ) bv_raw = BV_BLTZ;
      OP_J:       bv_raw = BV_JUMP;
      OP_JAL:     bv_raw = BV_JUMP_LINK;
      OP_BEQ:     bv_raw = BV_BEQ;
      OP_BNE:     bv_raw = BV_BNE;
      OP_SPECIAL: if (funct == F_JR) bv_raw = BV_JUMP_REG;
      default:    bv_raw = BV_NONE;
    endcase
  end

  // A stalled or empty Decode slot must not redirect Fetch.
  assign branch_variant_d = (valid_d && !hilo_stall_d) ? bv_raw : BV_NONE;

  always_comb begin
    ctrl_d = '0;
    if (is_special) begin
      ctrl_d.reg_write = !(funct inside {F_JR, F_SYSCALL, F_MULT, F_MULTU, F_DIV, F_DIVU});
    end else begin
      ctrl_d.reg_write = opcode inside {OP_ADDIU, OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI,
                                        OP_LW, OP_LB};
    end
    ctrl_d.mem_to_reg   = (opcode == OP_LW) || (opcode == OP_LB);
    ctrl_d.mem_write    = (opcode == OP_SW) || (opcode == OP_SB);
    ctrl_d.is_byte      = (opcode == OP_LB) || (opcode == OP_SB);
    ctrl_d.alu_src      = is_imm_type(opcode) || (is_special && (funct inside {F_SLL, F_SRA}));
    ctrl_d.reg_dest     = is_special;
    ctrl_d.syscall      = is_special && (funct == F_SYSCALL);
    ctrl_d.is_mf_hi     = is_special && (funct == F_MFHI);
    ctrl_d.is_mf_lo     = is_special && (funct == F_MFLO);
    ctrl_d.alu_op       = alu_op_decode(opcode, funct);
    ctrl_d.shamt        = (opcode == OP_LUI) ? 5'd16 : instr_shamt;
    ctrl_d.muldiv_op    = muldiv_d ? funct[1:0] : MULTDIV_MULT;  // funct[1:0] = MULTDIV_* code
    ctrl_d.muldiv_start = issue;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (flush_e || hilo_stall_d || !valid_d) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign reg_write_e    = ctrl_q.reg_write;
  assign mem_to_reg_e   = ctrl_q.mem_to_reg;
  assign mem_write_e    = ctrl_q.mem_write;
  assign alu_src_e      = ctrl_q.alu_src;
  assign reg_dest_e     = ctrl_q.reg_dest;
  assign syscall_e      = ctrl_q.syscall;
  assign is_mf_hi_e     = ctrl_q.is_mf_hi;
  assign is_mf_lo_e     = ctrl_q.is_mf_lo;
  assign is_byte_e      = ctrl_q.is_byte;
  assign alu_op_e       = ctrl_q.alu_op;
  assign shamt_e        = ctrl_q.shamt;
  assign muldiv_op_e    = ctrl_q.muldiv_op;
  assign muldiv_start_e = ctrl_q.muldiv_start;

endmodule

// File: tb/tb_hilo_control_unit.sv
module tb_hilo_control_unit;
  import hilo_control_unit_pkg::*;

  typedef struct packed {
    logic       rw, m2r, mw, asrc, rdst, sc, mfhi, mflo, byt;
    logic [3:0] alu;
    logic [4:0] sh;
    logic [1:0] mop;
    logic       start;
  } exec_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic [4:0] sh, rt;
    logic       valid, flush;
    logic [2:0] bv;
    logic       imm_u;
    exec_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic [4:0] instr_shamt, reg_rt_id;
  logic       valid_d, flush_e;
  logic [2:0] branch_variant_d;
  logic       imm_is_unsigned_d, hilo_stall_d;
  logic       reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dest_e, syscall_e;
  logic       is_mf_hi_e, is_mf_lo_e, is_byte_e, muldiv_start_e, hilo_busy, hilo_done;
  logic [3:0] alu_op_e;
  logic [4:0] shamt_e;
  logic [1:0] muldiv_op_e;

  int checks = 0;
  int failures = 0;
  exec_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  hilo_control_unit #(
    .MULT_LATENCY (4),
    .DIV_LATENCY  (4),
    .CNT_W        (6)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .opcode            (opcode),
    .funct             (funct),
    .instr_shamt       (instr_shamt),
    .reg_rt_id         (reg_rt_id),
    .valid_d           (valid_d),
    .flush_e           (flush_e),
    .branch_variant_d  (branch_variant_d),
    .imm_is_unsigned_d (imm_is_unsigned_d),
    .hilo_stall_d      (hilo_stall_d),
    .reg_write_e       (reg_write_e),
    .mem_to_reg_e      (mem_to_reg_e),
    .mem_write_e       (mem_write_e),
    .alu_src_e         (alu_src_e),
    .reg_dest_e        (reg_dest_e),
    .syscall_e         (syscall_e),
    .is_mf_hi_e        (is_mf_hi_e),
    .is_mf_lo_e        (is_mf_lo_e),
    .is_byte_e         (is_byte_e),
    .alu_op_e          (alu_op_e),
    .shamt_e           (shamt_e),
    .muldiv_op_e       (muldiv_op_e),
    .muldiv_start_e    (muldiv_start_e),
    .hilo_busy         (hilo_busy),
    .hilo_done         (hilo_done)
  );

  always #5 clk = ~clk;

  function automatic exec_t ex(input logic rw, m2r, mw, asrc, rdst, sc, mfhi, mflo, byt,
                               input logic [3:0] alu, input logic [4:0] sh,
                               input logic [1:0] mop, input logic start);
    ex = '{rw, m2r, mw, asrc, rdst, sc, mfhi, mflo, byt, alu, sh, mop, start};
  endfunction

  function automatic exec_t act_exec();
    act_exec = '{reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dest_e, syscall_e,
                 is_mf_hi_e, is_mf_lo_e, is_byte_e, alu_op_e, shamt_e, muldiv_op_e,
                 muldiv_start_e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, fn, input logic [4:0] sh, rt,
                       input logic valid, flush);
    @(negedge clk);
    opcode = op; funct = fn; instr_shamt = sh; reg_rt_id = rt;
    valid_d = valid; flush_e = flush;
    #1;
  endtask

  // Push the expected Execute bundle, clock once, pop and compare.
  task automatic cycle(input string nm, input exec_t exp);
    exec_t e;
    string n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk({n, "_exec"}, 32'(act_exec()), 32'(e));
    end
  endtask

  task automatic addv(input string nm, input logic [5:0] op, fn, input logic [4:0] sh, rt,
                      input logic valid, flush, input logic [2:0] bv, input logic imm_u,
                      input exec_t e);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.sh = sh; v.rt = rt; v.valid = valid;
    v.flush = flush; v.bv = bv; v.imm_u = imm_u; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = '0; funct = '0; instr_shamt = '0; reg_rt_id = '0; valid_d = 1'b0; flush_e = 1'b0;

    // Reset state: LUI held in Decode while reset is asserted
    drive(OP_LUI, 6'h00, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle("reset", '0);
    chk("reset_busy", 32'(hilo_busy), 32'd0);
    chk("reset_done", 32'(hilo_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //    name       op         fn        sh     rt    v  f  bv  imm
    addv("lui",     OP_LUI,    6'h21,    5'd3,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,1,0,0,0,0,0, 4'd8, 5'd16, 2'd0, 0));
    addv("jr",      OP_SPECIAL, F_JR,    5'd0,  5'd0, 1, 0, 3'd6, 0,
         ex(0,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd0, 0));
    addv("addu",    OP_SPECIAL, F_ADDU,  5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd0, 0));
    addv("subu",    OP_SPECIAL, F_SUBU,  5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,0,0,0, 4'd1, 5'd0, 2'd0, 0));
    addv("sll",     OP_SPECIAL, F_SLL,   5'd5,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,1,1,0,0,0,0, 4'd8, 5'd5, 2'd0, 0));
    addv("sra",     OP_SPECIAL, F_SRA,   5'd31, 5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,1,1,0,0,0,0, 4'd10, 5'd31, 2'd0, 0));
    addv("srl",     OP_SPECIAL, F_SRL,   5'd4,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,0,0,0, 4'd9, 5'd4, 2'd0, 0));
    addv("nor",     OP_SPECIAL, F_NOR,   5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,0,0,0, 4'd5, 5'd0, 2'd0, 0));
    addv("ori",     OP_ORI,    6'h00,    5'd2,  5'd0, 1, 0, 3'd0, 1,
         ex(1,0,0,1,0,0,0,0,0, 4'd3, 5'd2, 2'd0, 0));
    addv("sltiu",   OP_SLTIU,  6'h00,    5'd0,  5'd0, 1, 0, 3'd0, 1,
         ex(1,0,0,1,0,0,0,0,0, 4'd7, 5'd0, 2'd0, 0));
    addv("slti",    OP_SLTI,   6'h00,    5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,1,0,0,0,0,0, 4'd6, 5'd0, 2'd0, 0));
    addv("addiu",   OP_ADDIU,  6'h00,    5'd9,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,1,0,0,0,0,0, 4'd0, 5'd9, 2'd0, 0));
    addv("lw",      OP_LW,     6'h00,    5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,1,0,1,0,0,0,0,0, 4'd0, 5'd0, 2'd0, 0));
    addv("lb",      OP_LB,     6'h00,    5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,1,0,1,0,0,0,0,1, 4'd0, 5'd0, 2'd0, 0));
    addv("sw",      OP_SW,     6'h00,    5'd7,  5'd0, 1, 0, 3'd0, 0,
         ex(0,0,1,1,0,0,0,0,0, 4'd0, 5'd7, 2'd0, 0));
    addv("sb",      OP_SB,     6'h00,    5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(0,0,1,1,0,0,0,0,1, 4'd0, 5'd0, 2'd0, 0));
    addv("beq",     OP_BEQ,    6'h00,    5'd0,  5'd0, 1, 0, 3'd1, 0,
         ex(0,0,0,0,0,0,0,0,0, 4'd1, 5'd0, 2'd0, 0));
    addv("bne",     OP_BNE,    6'h00,    5'd0,  5'd0, 1, 0, 3'd2, 0,
         ex(0,0,0,0,0,0,0,0,0, 4'd1, 5'd0, 2'd0, 0));
    addv("bltz",    OP_REGIMM, 6'h00,    5'd0,  5'd0, 1, 0, 3'd3, 0, '0);
    addv("regimm1", OP_REGIMM, 6'h00,    5'd0,  5'd1, 1, 0, 3'd0, 0, '0);
    addv("j",       OP_J,      6'h00,    5'd0,  5'd0, 1, 0, 3'd4, 0, '0);
    addv("jal",     OP_JAL,    6'h00,    5'd0,  5'd0, 1, 0, 3'd5, 0, '0);
    addv("syscall", OP_SPECIAL, F_SYSCALL, 5'd0, 5'd0, 1, 0, 3'd0, 0,
         ex(0,0,0,0,1,1,0,0,0, 4'd0, 5'd0, 2'd0, 0));
    addv("mfhi",    OP_SPECIAL, F_MFHI,  5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,1,0,0, 4'd0, 5'd0, 2'd0, 0));
    addv("mflo",    OP_SPECIAL, F_MFLO,  5'd0,  5'd0, 1, 0, 3'd0, 0,
         ex(1,0,0,0,1,0,0,1,0, 4'd0, 5'd0, 2'd0, 0));
    addv("beq_inv", OP_BEQ,    6'h00,    5'd0,  5'd0, 0, 0, 3'd0, 0, '0);
    addv("jr_flush", OP_SPECIAL, F_JR,   5'd0,  5'd0, 1, 1, 3'd6, 0, '0);
    addv("ori_inv", OP_ORI,    6'h00,    5'd0,  5'd0, 0, 0, 3'd0, 1, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].rt, vecs[i].valid, vecs[i].flush);
      chk({vecs[i].name, "_bv"}, 32'(branch_variant_d), 32'(vecs[i].bv));
      chk({vecs[i].name, "_immu"}, 32'(imm_is_unsigned_d), 32'(vecs[i].imm_u));
      cycle(vecs[i].name, vecs[i].exp);
    end

    // DIV then MFLO held in Decode: stalled cycles 1-4, done in cycle 4, proceeds at edge 5
    drive(OP_SPECIAL, F_DIV, 5'd0, 5'd0, 1, 0);
    chk("div_stall0", 32'(hilo_stall_d), 32'd0);
    cycle("div_issue", ex(0,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd2, 1));
    for (int k = 1; k <= 4; k++) begin
      drive(OP_SPECIAL, F_MFLO, 5'd0, 5'd0, 1, 0);
      chk($sformatf("mflo_stall_c%0d", k), 32'(hilo_stall_d), 32'd1);
      chk($sformatf("mflo_busy_c%0d", k), 32'(hilo_busy), 32'd1);
      chk($sformatf("mflo_done_c%0d", k), 32'(hilo_done), 32'(k == 4));
      cycle($sformatf("mflo_bubble_c%0d", k), '0);
    end
    drive(OP_SPECIAL, F_MFLO, 5'd0, 5'd0, 1, 0);
    chk("mflo_go_stall", 32'(hilo_stall_d), 32'd0);
    chk("mflo_go_busy", 32'(hilo_busy), 32'd0);
    cycle("mflo_go", ex(1,0,0,0,1,0,0,1,0, 4'd0, 5'd0, 2'd0, 0));

    // MULT then DIVU: DIVU stalls four cycles, then issues with op 3
    drive(OP_SPECIAL, F_MULT, 5'd0, 5'd0, 1, 0);
    cycle("mult_issue", ex(0,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd0, 1));
    for (int k = 1; k <= 4; k++) begin
      drive(OP_SPECIAL, F_DIVU, 5'd0, 5'd0, 1, 0);
      chk($sformatf("divu_stall_c%0d", k), 32'(hilo_stall_d), 32'd1);
      chk($sformatf("mult_done_c%0d", k), 32'(hilo_done), 32'(k == 4));
      cycle($sformatf("divu_bubble_c%0d", k), '0);
    end
    drive(OP_SPECIAL, F_DIVU, 5'd0, 5'd0, 1, 0);
    cycle("divu_issue", ex(0,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd3, 1));
    // flush_e while busy must not cancel the in-flight DIVU
    for (int k = 1; k <= 4; k++) begin
      drive(OP_SPECIAL, F_ADDU, 5'd0, 5'd0, 1, 1);
      chk($sformatf("divu_flush_busy_c%0d", k), 32'(hilo_busy), 32'd1);
      chk($sformatf("divu_flush_done_c%0d", k), 32'(hilo_done), 32'(k == 4));
      cycle($sformatf("divu_flush_c%0d", k), '0);
    end
    chk("divu_idle", 32'(hilo_busy), 32'd0);

    // DIV with flush_e: no issue, sequencer stays idle
    drive(OP_SPECIAL, F_DIV, 5'd0, 5'd0, 1, 1);
    cycle("div_flush", '0);
    chk("div_flush_busy", 32'(hilo_busy), 32'd0);

    // Reset two cycles after a DIV issue abandons it with no done pulse
    drive(OP_SPECIAL, F_DIV, 5'd0, 5'd0, 1, 0);
    cycle("rst_div_issue", ex(0,0,0,0,1,0,0,0,0, 4'd0, 5'd0, 2'd2, 1));
    drive(OP_SPECIAL, F_ADDU, 5'd0, 5'd0, 0, 0);
    cycle("rst_div_c1", '0);
    drive(OP_LUI, 6'h00, 5'd0, 5'd0, 1, 0);
    reset_n = 1'b0;
    cycle("rst_mid", '0);
    chk("rst_mid_busy", 32'(hilo_busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    valid_d = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_no_done_%0d", k), 32'(hilo_done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
